// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_tracker instruction pipeline.
// Holds the STOP opcode, the instruction field positions and the bubble
// constant used by the tracker. The field decode covers the low 8 bits of
// an instruction; wider instructions carry extra payload above bit 7.
// Ports: none (package).
package pipe_pkg;

    localparam int          FIELD_W  = 8;        // bits covered by the decode
    localparam int          REG_W    = 2;        // register index width
    localparam int          OP_W     = 4;        // opcode width
    localparam int          DEST_LSB = 6;        // [7:6] dest / src1
    localparam int          SRC2_LSB = 4;        // [5:4] src2
    localparam int          OP_LSB   = 0;        // [3:0] opcode
    localparam logic [3:0]  STOP_OP  = 4'b0001;

    // Per-stage control bits. A bubble has both cleared and a zero instruction.
    typedef struct packed {
        logic valid;
        logic wr;
    } stage_ctl_t;

    localparam stage_ctl_t  BUBBLE_CTL   = '{valid: 1'b0, wr: 1'b0};
    localparam logic [FIELD_W-1:0] BUBBLE_INSTR = '0;

    function automatic logic [REG_W-1:0] dest_of(input logic [FIELD_W-1:0] instr);
        return instr[DEST_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] src2_of(input logic [FIELD_W-1:0] instr);
        return instr[SRC2_LSB +: REG_W];
    endfunction

    function automatic logic [OP_W-1:0] op_of(input logic [FIELD_W-1:0] instr);
        return instr[OP_LSB +: OP_W];
    endfunction

endpackage

// File: rtl/pipe_tracker_sat_counter.sv
// Saturating up-counter used for the pipe_tracker performance counters.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-low; clears the count
//   inc   - add one this cycle (ignored once the count is all-ones)
//   count - current count value
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CW{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_tracker.sv
// In-order instruction pipeline tracker with RAW hazard stalls, flush,
// STOP-triggered halt and saturating performance counters.
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-low reset
//   fetch_valid/instr/wr      - instruction offered at the fetch side
//   flush                     - kill the instructions in stages 0 and 1
//   fetch_ready               - offered instruction is accepted this cycle
//   stage_instr/stage_valid   - flattened stage registers and valid bits
//   hazard                    - RAW hazard holding stage 1 this cycle
//   halted                    - a STOP instruction has retired
//   cycle/retire/stall_count  - saturating performance counters
module pipe_tracker
    import pipe_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int IW     = 8,
    parameter int CW     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [IW-1:0]        fetch_instr,
    input  logic                 fetch_wr,
    input  logic                 flush,
    output logic                 fetch_ready,
    output logic [STAGES*IW-1:0] stage_instr,
    output logic [STAGES-1:0]    stage_valid,
    output logic                 hazard,
    output logic                 halted,
    output logic [CW-1:0]        cycle_count,
    output logic [CW-1:0]        retire_count,
    output logic [CW-1:0]        stall_count
);

    localparam int LAST = STAGES - 1;

    logic [IW-1:0] instr_q [STAGES];
    logic [IW-1:0] instr_d [STAGES];
    stage_ctl_t    ctl_q   [STAGES];
    stage_ctl_t    ctl_d   [STAGES];
    logic          halted_q;
    logic          halted_d;

    logic          stop_in_flight;
    logic          accept;
    logic          retire_inc;
    logic          cycle_inc;
    logic          stall_inc;

    // Stage 1 reads dest/src1 and src2; any older valid writer of either
    // register forces a stall since results are never bypassed.
    always_comb begin
        hazard = 1'b0;
        if (ctl_q[1].valid) begin
            for (int j = 2; j < STAGES; j++) begin
                if (ctl_q[j].valid && ctl_q[j].wr &&
                    ((dest_of(instr_q[j][FIELD_W-1:0]) == dest_of(instr_q[1][FIELD_W-1:0])) ||
                     (dest_of(instr_q[j][FIELD_W-1:0]) == src2_of(instr_q[1][FIELD_W-1:0])))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // A STOP anywhere in the pipe blocks further fetches so that nothing
    // younger than it can retire after the halt.
    always_comb begin
        stop_in_flight = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (ctl_q[k].valid && (op_of(instr_q[k][FIELD_W-1:0]) == STOP_OP)) begin
                stop_in_flight = 1'b1;
            end
        end
    end

    assign fetch_ready = !halted_q && !hazard && !flush && !stop_in_flight;
    assign accept      = fetch_valid && fetch_ready;

    // Stage advance: flush wins over hazard; halted freezes everything.
    always_comb begin
        instr_d  = instr_q;
        ctl_d    = ctl_q;
        halted_d = halted_q;
        if (!halted_q) begin
            for (int k = 2; k < STAGES; k++) begin
                instr_d[k] = instr_q[k-1];
                ctl_d[k]   = ctl_q[k-1];
            end
            if (flush) begin
                instr_d[0] = IW'(BUBBLE_INSTR);
                ctl_d[0]   = BUBBLE_CTL;
                instr_d[1] = IW'(BUBBLE_INSTR);
                ctl_d[1]   = BUBBLE_CTL;
            end else if (hazard) begin
                // Stages 0 and 1 hold (defaults); a bubble enters behind them.
                instr_d[0] = instr_q[0];
                ctl_d[0]   = ctl_q[0];
                instr_d[1] = instr_q[1];
                ctl_d[1]   = ctl_q[1];
                instr_d[2] = IW'(BUBBLE_INSTR);
                ctl_d[2]   = BUBBLE_CTL;
            end else begin
                instr_d[1] = instr_q[0];
                ctl_d[1]   = ctl_q[0];
                if (accept) begin
                    instr_d[0] = fetch_instr;
                    ctl_d[0]   = '{valid: 1'b1, wr: fetch_wr};
                end else begin
                    instr_d[0] = IW'(BUBBLE_INSTR);
                    ctl_d[0]   = BUBBLE_CTL;
                end
            end
            if (ctl_q[LAST].valid && (op_of(instr_q[LAST][FIELD_W-1:0]) == STOP_OP)) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                instr_q[k] <= IW'(BUBBLE_INSTR);
                ctl_q[k]   <= BUBBLE_CTL;
            end
            halted_q <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            ctl_q    <= ctl_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        stage_instr = '0;
        stage_valid = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_instr[k*IW +: IW] = instr_q[k];
            stage_valid[k]          = ctl_q[k].valid;
        end
    end

    assign halted     = halted_q;
    assign cycle_inc  = !halted_q;
    assign retire_inc = !halted_q && ctl_q[LAST].valid;
    assign stall_inc  = !halted_q && hazard && !flush;

    sat_counter #(.CW(CW)) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (cycle_inc),
        .count (cycle_count)
    );

    sat_counter #(.CW(CW)) u_retire_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (retire_inc),
        .count (retire_count)
    );

    sat_counter #(.CW(CW)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

endmodule

// File: doc/pipe_tracker.md
PIPE_TRACKER -- requirements
Module: pipe_tracker

Interface
REQ-001 Parameter STAGES, 4, number of pipelined instruction-register stages (legal range 3..8; stage 0 = fetch side, stage STAGES-1 = write-back).
REQ-002 Parameter IW, 8, instruction width in bits.
REQ-003 Parameter CW, 16, width of each performance counter.
REQ-004 Port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  reset, synchronous and active-low.
REQ-006 Port fetch_valid  in  1  fetch_instr holds a valid instruction this cycle.
REQ-007 Port fetch_instr  in  IW  instruction; [7:6] dest/src1 register, [5:4] src2 register, [3:0] opcode.
REQ-008 Port fetch_wr  in  1  the fetched instruction writes register fetch_instr[7:6].
REQ-009 Port flush  in  1  kill the instructions in stages 0 and 1.
REQ-010 Port fetch_ready  out  1  an offered instruction is accepted this cycle.
REQ-011 Port stage_instr  out  STAGES*IW  flattened stage registers; stage k occupies bits [k*IW +: IW].
REQ-012 Port stage_valid  out  STAGES  per-stage valid bits.
REQ-013 Port hazard  out  1  RAW hazard detected this cycle.
REQ-014 Port halted  out  1  a STOP instruction has retired.
REQ-015 Ports cycle_count, retire_count, stall_count  out  CW each  performance counters.

Function
REQ-016 Bubble: valid=0, instr=0, wr=0.
REQ-017 Hazard = stage_valid[1] && exists j in 2..STAGES-1 with stage_valid[j], wr[j] and dest[j] equal to src1 or src2 of stage 1; no bypassing.
REQ-018 stop_in_flight = any valid stage whose opcode equals STOP_OP (4'b0001).
REQ-019 fetch_ready = !halted && !hazard && !flush && !stop_in_flight (combinational).
REQ-020 Normal cycle (not halted, no flush, no hazard): every stage k>0 takes stage k-1; stage 0 takes {fetch_instr, fetch_wr, valid=1} if fetch_valid && fetch_ready, else a bubble.
REQ-021 Hazard cycle without flush: stages 0 and 1 hold, stage 2 takes a bubble, stages 3..STAGES-1 shift, stall_count increments.
REQ-022 Flush cycle: stages 0 and 1 become bubbles, stages 2..STAGES-1 shift; flush overrides hazard and stall_count does not increment.
REQ-023 Retire: stage STAGES-1 valid increments retire_count in that cycle.
REQ-024 Valid STOP in stage STAGES-1 retires (counted) and sets halted at the next edge.
REQ-025 While halted, all stages, counters and halted are frozen; fetch_valid and flush are ignored.
REQ-026 cycle_count increments each non-halted cycle, including the cycle the STOP retires.
REQ-027 All counters saturate at all-ones and never wrap.
REQ-028 Latency: an instruction accepted at edge n is in stage k after edge n+1+k when no hazard or flush intervenes.

Reset
REQ-029 While reset is low at a clock edge: all stage_valid=0, stage_instr=0, wr=0, counters=0, halted=0; hazard=0 and fetch_ready=1 in the first cycle after release.
REQ-030 Reset mid-operation (including while halted) discards all in-flight instructions with no retire counted.

Structure
REQ-031 A shared package pipe_pkg holds STOP_OP, the field positions (dest, src2, opcode) and the bubble constant.
REQ-032 One sub-module, sat_counter (parameter CW; inputs clock, reset, inc), is instantiated three times for the counters; hazard compare stays inline.

Verification (STAGES=4, CW=16 unless stated)
REQ-033 Reset low for 2 cycles -> stage_valid=4'b0000, all counters 0, fetch_ready=1, halted=0.
REQ-034 Independent 8'h02, 8'h52, 8'hA2 (wr=1, dest r0/r1/r2, no shared sources) -> each reaches stage 3 four edges after acceptance, retire_count=3, stall_count=0.
REQ-035 8'h42 (wr=1, dest r1) then 8'h42 reading r1 -> hazard high for exactly 2 cycles, stall_count=2, second instruction retires 2 cycles later than in REQ-034.
REQ-036 flush asserted in a hazard cycle -> stage_valid[1:0]=2'b00 next cycle, stall_count unchanged, older stages shift normally.
REQ-037 Fetch 8'h01 (STOP) -> fetch_ready low from the next cycle, halted=1 one edge after STOP reaches stage 3, retire_count includes it, counters frozen for 10 further cycles with fetch_valid=1.
REQ-038 CW=4, fetch_valid=0 for 20 cycles -> cycle_count=4'hF and held.
